// File: rtl/arb_pkg.sv
// Shared types and defaults for the upstream port arbiter.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} arb_state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_MAX_BURST = 4;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: round-robin after i_last by default,
// lowest-index fixed priority when ARB_FIXED_PRIO_EN is defined.
module rr_pick import arb_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last,
  output logic [ID_W-1:0]  o_winner,
  output logic             o_any
);
  assign o_any = |i_req;

`ifdef ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = ^i_last;

  always_comb begin
    o_winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (i_req[i]) o_winner = ID_W'(i);
  end
`else
  int w_best;
  int w_dist;

  // Rotational distance from last grant; the smallest distance wins.
  always_comb begin
    o_winner = '0;
    w_best   = N_REQ;
    w_dist   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = (i + N_REQ - 1 - int'(i_last)) % N_REQ;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_winner = ID_W'(i);
      end
    end
  end
`endif
endmodule

// File: rtl/up_port_arbiter.sv
// Burst-limited scheduler sharing one registered upstream channel among N_REQ
// requesters. Define ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module up_port_arbiter import arb_pkg::*; #(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int ID_W      = id_width(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_addr,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   req_rdy,
  output logic [7:0]         addr_out,
  output logic [7:0]         data_out,
  output logic               valid_out,
  input  logic               data_rd,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy
);
  if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_param
    $fatal(1, "up_port_arbiter: N_REQ or MAX_BURST out of range");
  end

  arb_state_e       r_state, w_next;
  logic [7:0]       r_addr, r_data;
  logic             r_valid;
  logic [ID_W-1:0]  r_grant, r_last;
  logic [3:0]       r_beat_cnt;

  logic             w_out_free, w_gvalid, w_pop, w_any, w_last_beat;
  logic [7:0]       w_gaddr, w_gdata;
  logic [ID_W-1:0]  w_winner;
  logic [N_REQ-1:0] w_rdy;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .i_req    (req_valid),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_out_free  = !r_valid || data_rd;
  assign w_last_beat = (r_beat_cnt == 4'(MAX_BURST - 1));

  // Pop is suppressed during reset so a held beat is never replaced mid-reset.
  always_comb begin
    w_gvalid = 1'b0;
    w_gaddr  = '0;
    w_gdata  = '0;
    for (int i = 0; i < N_REQ; i++)
      if (r_grant == ID_W'(i)) begin
        w_gvalid = req_valid[i];
        w_gaddr  = req_addr[8*i +: 8];
        w_gdata  = req_data[8*i +: 8];
      end
    w_pop = (r_state == XFER) && w_out_free && w_gvalid && !rst_b;
    for (int i = 0; i < N_REQ; i++)
      w_rdy[i] = w_pop && (r_grant == ID_W'(i));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = XFER;
      XFER:    if (w_out_free) begin
                 if (!w_gvalid || w_last_beat) w_next = DRAIN;
               end
      DRAIN:   if (w_out_free) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_grant    <= '0;
      r_last     <= ID_W'(N_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_addr     <= w_gaddr;
        r_data     <= w_gdata;
        r_valid    <= 1'b1;
        r_beat_cnt <= r_beat_cnt + 4'd1;
      end else if (data_rd) begin
        r_valid <= 1'b0;
      end
      if (r_state == IDLE && w_any) begin
        r_grant    <= w_winner;
        r_beat_cnt <= '0;
      end
      if (r_state == DRAIN && w_out_free) r_last <= r_grant;
    end
  end

  assign req_rdy   = w_rdy;
  assign addr_out  = r_addr;
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign grant_id  = r_grant;
  assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_up_port_arbiter.sv
// Directed bench for up_port_arbiter (N_REQ=4, MAX_BURST=4).
module tb_up_port_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst_b;
  logic [N-1:0] req_valid;
  logic [N*8-1:0] req_addr, req_data;
  logic [N-1:0] req_rdy;
  logic [7:0]   addr_out, data_out;
  logic         valid_out, data_rd;
  logic [1:0]   grant_id;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  up_port_arbiter #(.N_REQ(N), .MAX_BURST(MB), .ID_W(2)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_rdy(req_rdy), .addr_out(addr_out),
    .data_out(data_out), .valid_out(valid_out), .data_rd(data_rd),
    .grant_id(grant_id), .busy(busy)
  );

  task automatic tick;
    @(posedge clk); #2;
  endtask

  task automatic do_reset;
    rst_b = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; data_rd = 1'b1;
    tick; tick;
    rst_b = 1'b0;
  endtask

  task automatic test_reset;
    do_reset; #1;
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_out); end
    n_tests++; if (addr_out !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", addr_out); end
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_out); end
    n_tests++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy got %b want 0000", req_rdy); end
    n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant got %0d want 0", grant_id); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single;
    logic [3:0] e_rdy [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic       e_v   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] e_d   [6] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'h00, 8'h00};
    logic       e_b   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int n;
    do_reset; n = 0;
    req_valid = 4'b0100; req_addr[23:16] = 8'h22; req_data[23:16] = 8'hA0;
    tick;
    n_tests++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_grant got %0d want 2", grant_id); end
    for (int c = 0; c < 6; c++) begin
      req_valid = (n < 3) ? 4'b0100 : 4'b0000;
      req_data[23:16] = 8'hA0 + 8'(n);
      #1;
      n_tests++; if (req_rdy !== e_rdy[c]) begin n_fail++; $display("FAIL single_rdy c%0d got %b want %b", c + 1, req_rdy, e_rdy[c]); end
      n_tests++; if (valid_out !== e_v[c]) begin n_fail++; $display("FAIL single_valid c%0d got %b want %b", c + 1, valid_out, e_v[c]); end
      n_tests++; if (busy !== e_b[c]) begin n_fail++; $display("FAIL single_busy c%0d got %b want %b", c + 1, busy, e_b[c]); end
      if (e_v[c]) begin
        n_tests++; if (data_out !== e_d[c] || addr_out !== 8'h22) begin
          n_fail++; $display("FAIL single_beat c%0d got %h/%h want 22/%h", c + 1, addr_out, data_out, e_d[c]);
        end
      end
      if (req_rdy[2]) n++;
      tick;
    end
  endtask

  task automatic test_fairness;
    logic [7:0] q[$];
    logic [7:0] exp;
    int cnt [4];
    int order [6];
    int beats [6];
    int g;
    logic pb;
    do_reset;
    g = 0; pb = 1'b0;
    cnt = '{default: 0}; order = '{default: -1}; beats = '{default: 0};
    req_valid = 4'hF;
    for (int c = 0; c < 80 && g < 5; c++) begin
      for (int i = 0; i < N; i++) begin
        req_addr[8*i +: 8] = {4'(i), 4'(cnt[i])};
        req_data[8*i +: 8] = 8'(c);
      end
      #1;
      if (busy && !pb) begin order[g] = grant_id; g++; end
      if (valid_out && data_rd) begin
        n_tests++;
        if (q.size() == 0) begin n_fail++; $display("FAIL fair_extra got %h want none", addr_out); end
        else begin
          exp = q.pop_front();
          if (addr_out !== exp) begin n_fail++; $display("FAIL fair_beat got %h want %h", addr_out, exp); end
        end
      end
      if (req_rdy != 4'b0000) begin
        n_tests++; if (!$onehot(req_rdy)) begin n_fail++; $display("FAIL fair_onehot got %b want one-hot", req_rdy); end
        for (int i = 0; i < N; i++)
          if (req_rdy[i]) begin
            q.push_back({4'(i), 4'(cnt[i])});
            cnt[i]++;
            if (g > 0) beats[g-1]++;
          end
      end
      pb = busy;
      tick;
    end
    n_tests++; if (g < 5) begin n_fail++; $display("FAIL fair_timeout got %0d grants want 5", g); end
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (order[k] != (k % 4)) begin n_fail++; $display("FAIL fair_order%0d got %0d want %0d", k, order[k], k % 4); end
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (beats[k] != MB) begin n_fail++; $display("FAIL fair_beats%0d got %0d want %0d", k, beats[k], MB); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    do_reset; n = 0;
    req_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      req_addr[7:0] = 8'h10 + 8'(n);
      req_data[7:0] = 8'h50 + 8'(n);
      data_rd = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
      #1;
      if (c >= 3 && c <= 7) begin
        n_tests++; if (valid_out !== 1'b1 || addr_out !== 8'h11 || data_out !== 8'h51) begin
          n_fail++; $display("FAIL bp_hold c%0d got %b %h/%h want 1 11/51", c, valid_out, addr_out, data_out);
        end
        n_tests++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_rdy c%0d got %b want 0000", c, req_rdy); end
      end
      if (c == 8) begin
        n_tests++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL bp_resume_rdy got %b want 0001", req_rdy); end
      end
      if (c == 9) begin
        n_tests++; if (valid_out !== 1'b1 || addr_out !== 8'h12 || data_out !== 8'h52) begin
          n_fail++; $display("FAIL bp_next got %b %h/%h want 1 12/52", valid_out, addr_out, data_out);
        end
      end
      if (req_rdy[0]) n++;
      tick;
    end
    data_rd = 1'b1;
  endtask

  task automatic test_early_end;
    int n;
    logic [1:0] e_next;
`ifdef ARB_FIXED_PRIO_EN
    e_next = 2'd0;
`else
    e_next = 2'd2;
`endif
    do_reset; n = 0;
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 3) ? 4'b0010 : 4'b0101;
      req_addr[15:8] = 8'h30 + 8'(n);
      #1;
      case (c)
        1: begin
          n_tests++; if (grant_id !== 2'd1 || req_rdy !== 4'b0010) begin
            n_fail++; $display("FAIL early_c1 got %0d %b want 1 0010", grant_id, req_rdy);
          end
        end
        2: begin
          n_tests++; if (req_rdy !== 4'b0010) begin n_fail++; $display("FAIL early_c2 got %b want 0010", req_rdy); end
        end
        3: begin
          n_tests++; if (req_rdy !== 4'b0000 || valid_out !== 1'b1 || addr_out !== 8'h31) begin
            n_fail++; $display("FAIL early_c3 got %b %b %h want 0000 1 31", req_rdy, valid_out, addr_out);
          end
        end
        4: begin
          n_tests++; if (busy !== 1'b1 || req_rdy !== 4'b0000 || valid_out !== 1'b0) begin
            n_fail++; $display("FAIL early_drain got %b %b %b want 1 0000 0", busy, req_rdy, valid_out);
          end
        end
        5: begin
          n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL early_idle got %b want 0", busy); end
        end
        6: begin
          n_tests++; if (grant_id !== e_next || busy !== 1'b1) begin
            n_fail++; $display("FAIL early_next got %0d %b want %0d 1", grant_id, busy, e_next);
          end
        end
        default: ;
      endcase
      if (req_rdy[1]) n++;
      tick;
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    req_valid = 4'b0010; req_addr[15:8] = 8'h44;
    tick;
    tick; #1;
    n_tests++; if (valid_out !== 1'b1 || grant_id !== 2'd1) begin
      n_fail++; $display("FAIL rmid_pre got %b %0d want 1 1", valid_out, grant_id);
    end
    rst_b = 1'b1; req_valid = 4'b0111; #1;
    n_tests++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL rmid_nopop got %b want 0000", req_rdy); end
    tick;
    n_tests++; if (valid_out !== 1'b0 || busy !== 1'b0 || req_rdy !== 4'b0000) begin
      n_fail++; $display("FAIL rmid_cleared got %b %b %b want 0 0 0000", valid_out, busy, req_rdy);
    end
    rst_b = 1'b0;
    tick; #1;
    n_tests++; if (busy !== 1'b1 || grant_id !== 2'd0 || req_rdy !== 4'b0001) begin
      n_fail++; $display("FAIL rmid_regrant got %b %0d %b want 1 0 0001", busy, grant_id, req_rdy);
    end
  endtask

  task automatic test_two_req;
    int order [4];
    int beats [4];
    int exp_o [3];
    int g;
    logic pb;
`ifdef ARB_FIXED_PRIO_EN
    exp_o = '{0, 0, 0};
`else
    exp_o = '{0, 3, 0};
`endif
    do_reset;
    g = 0; pb = 1'b0; order = '{default: -1}; beats = '{default: 0};
    req_valid = 4'b1001;
    for (int c = 0; c < 60 && g < 4; c++) begin
      #1;
      if (busy && !pb) begin order[g] = grant_id; g++; end
      if (req_rdy != 4'b0000 && g > 0) beats[g-1]++;
      pb = busy;
      tick;
    end
    n_tests++; if (g < 4) begin n_fail++; $display("FAIL two_timeout got %0d grants want 4", g); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (order[k] != exp_o[k]) begin n_fail++; $display("FAIL two_order%0d got %0d want %0d", k, order[k], exp_o[k]); end
      n_tests++; if (beats[k] != MB) begin n_fail++; $display("FAIL two_beats%0d got %0d want %0d", k, beats[k], MB); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_backpressure;
    test_early_end;
    test_reset_mid;
    test_two_req;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
